axi_test_sequencer: RTL and testbench

- Host-side controller that drives the AXI register port of the prewrapped DUT/DFT design through one complete test transaction.
- Sequence per command:
  - write the DUT input vector and start the DUT operation;
  - poll until the DUT completes, then read the DUT output;
  - trigger DUMP_NBR scan dumps and read each DFT word.
- Results leave on a valid/ready stream.
- Sits between a host or testbench command source and the prewrapped design's axi_rd_*/axi_wr_* ports.

---
 rtl/axi_seq_pkg.sv | 19 +
 rtl/axi_seq_if.sv | 23 ++
 rtl/axi_seq_poller.sv | 31 +++
 rtl/axi_test_sequencer.sv | 91 +++++++++
 tb/tb_axi_test_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi_seq_pkg.sv
// axi_seq_pkg: shared states, register map defaults and CTRL/STAT bit positions
package axi_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, WR_IN, WR_GO, POLL_DUT, RD_OUT, EMIT_OUT,
    DFT_GO, POLL_DFT, DFT_RD, EMIT_DFT, EMIT_ERR
  } state_t;
  localparam logic [31:0] A_NOP  = 32'h0;
  localparam logic [31:0] A_IN   = 32'h4;
  localparam logic [31:0] A_CTRL = 32'h8;
  localparam logic [31:0] A_STAT = 32'hC;
  localparam logic [31:0] A_OUT  = 32'h10;
  localparam logic [31:0] A_DFT  = 32'h14;
  localparam int CTRL_DUT_GO   = 0;
  localparam int CTRL_DFT_GO   = 1;
  localparam int STAT_DUT_DONE = 0;
  localparam int STAT_DFT_STB  = 1;
  localparam logic [31:0] GO_DUT = 32'd1 << CTRL_DUT_GO;
  localparam logic [31:0] GO_DFT = 32'd1 << CTRL_DFT_GO;
endpackage

// File: rtl/axi_seq_if.sv
// axi_seq_if: command stream, result stream and AXI register port of the sequencer
interface axi_seq_if;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [31:0] cmd_data;
  logic        res_val;
  logic        res_rdy;
  logic [31:0] res_data;
  logic        res_is_dft;
  logic        res_last;
  logic [31:0] axi_wr_addr;
  logic [31:0] axi_wr_msg;
  logic [31:0] axi_rd_addr;
  logic [31:0] axi_rd_msg;
  modport master (
    input  cmd_val, cmd_data, res_rdy, axi_rd_msg,
    output cmd_rdy, res_val, res_data, res_is_dft, res_last, axi_wr_addr, axi_wr_msg, axi_rd_addr
  );
  modport slave (
    output cmd_val, cmd_data, res_rdy, axi_rd_msg,
    input  cmd_rdy, res_val, res_data, res_is_dft, res_last, axi_wr_addr, axi_wr_msg, axi_rd_addr
  );
endinterface

// File: rtl/axi_seq_poller.sv
// axi_seq_poller: alternating STAT read/sample cycles, bit test and saturating poll-read count
module axi_seq_poller import axi_seq_pkg::*; #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       sel,
  input  logic [1:0] stat,
  output logic       req,
  output logic       done,
  output logic       timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic          ph;
  logic [CW-1:0] cnt;
  logic          hit;
  assign hit     = sel ? stat[STAT_DFT_STB] : stat[STAT_DUT_DONE];
  assign req     = en && !ph;
  assign done    = en && ph && hit;
  assign timeout = en && ph && !hit && cnt == CW'(TIMEOUT - 1);
  // counter clears whenever polling stops, so each wait starts from zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ph  <= 1'b0;
      cnt <= '0;
    end else begin
      ph  <= en && !ph;
      cnt <= !en ? '0 : (ph && cnt != CW'(TIMEOUT)) ? cnt + CW'(1) : cnt;
    end
endmodule

// File: rtl/axi_test_sequencer.sv
// axi_test_sequencer: drives one DUT run plus DUMP_NBR scan dumps over the AXI register port
module axi_test_sequencer import axi_seq_pkg::*; #(
  parameter int unsigned DUMP_NBR  = 1,
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [31:0] ADDR_NOP  = A_NOP,
  parameter logic [31:0] ADDR_IN   = A_IN,
  parameter logic [31:0] ADDR_CTRL = A_CTRL,
  parameter logic [31:0] ADDR_STAT = A_STAT,
  parameter logic [31:0] ADDR_OUT  = A_OUT,
  parameter logic [31:0] ADDR_DFT  = A_DFT
) (
  input  logic     clk,
  input  logic     reset,
  axi_seq_if.master bus,
  output logic     busy,
  output logic     err
);
  state_t      state, nxt;
  logic [31:0] vec;
  logic [15:0] cnt;
  logic        rd_ph, last_dft;
  logic        poll_req, poll_done, poll_to;
  assign last_dft = cnt == 16'(DUMP_NBR - 1);
  axi_seq_poller #(.TIMEOUT(TIMEOUT)) u_poll (
    .clk(clk), .reset(reset),
    .en(state == POLL_DUT || state == POLL_DFT), .sel(state == POLL_DFT),
    .stat(bus.axi_rd_msg[1:0]),
    .req(poll_req), .done(poll_done), .timeout(poll_to)
  );
  assign busy          = state != IDLE;
  assign bus.cmd_rdy   = reset && state == IDLE;
  assign bus.res_val   = state == EMIT_OUT || state == EMIT_DFT || state == EMIT_ERR;
  assign bus.axi_wr_addr = state == WR_IN ? ADDR_IN :
                           (state == WR_GO || state == DFT_GO) ? ADDR_CTRL : ADDR_NOP;
  assign bus.axi_wr_msg  = state == WR_IN ? vec : state == WR_GO ? GO_DUT :
                           state == DFT_GO ? GO_DFT : '0;
  assign bus.axi_rd_addr = poll_req ? ADDR_STAT : (state == RD_OUT && !rd_ph) ? ADDR_OUT :
                           (state == DFT_RD && !rd_ph) ? ADDR_DFT : ADDR_NOP;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = bus.cmd_val ? WR_IN : IDLE;
      WR_IN:    nxt = WR_GO;
      WR_GO:    nxt = POLL_DUT;
      POLL_DUT: nxt = poll_done ? RD_OUT : poll_to ? EMIT_ERR : POLL_DUT;
      RD_OUT:   nxt = rd_ph ? EMIT_OUT : RD_OUT;
      EMIT_OUT: nxt = !bus.res_rdy ? EMIT_OUT : DUMP_NBR == 0 ? IDLE : DFT_GO;
      DFT_GO:   nxt = POLL_DFT;
      POLL_DFT: nxt = poll_done ? DFT_RD : poll_to ? EMIT_ERR : POLL_DFT;
      DFT_RD:   nxt = rd_ph ? EMIT_DFT : DFT_RD;
      EMIT_DFT: nxt = !bus.res_rdy ? EMIT_DFT : last_dft ? IDLE : DFT_GO;
      EMIT_ERR: nxt = bus.res_rdy ? IDLE : EMIT_ERR;
      default:  nxt = IDLE;
    endcase
  end
  // result word is captured on entry to an emit state and held through any stall
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state          <= IDLE;
      vec            <= '0;
      cnt            <= '0;
      rd_ph          <= 1'b0;
      err            <= 1'b0;
      bus.res_data   <= '0;
      bus.res_is_dft <= 1'b0;
      bus.res_last   <= 1'b0;
    end else begin
      state <= nxt;
      rd_ph <= (state == RD_OUT || state == DFT_RD) && !rd_ph;
      if (state == IDLE && bus.cmd_val) begin
        vec <= bus.cmd_data;
        err <= 1'b0;
      end
      if (poll_to) err <= 1'b1;
      if (state == EMIT_OUT && bus.res_rdy) cnt <= '0;
      else if (state == EMIT_DFT && bus.res_rdy) cnt <= cnt + 16'd1;
      if (state == RD_OUT && rd_ph) begin
        bus.res_data   <= bus.axi_rd_msg;
        bus.res_is_dft <= 1'b0;
        bus.res_last   <= DUMP_NBR == 0;
      end else if (state == DFT_RD && rd_ph) begin
        bus.res_data   <= bus.axi_rd_msg;
        bus.res_is_dft <= 1'b1;
        bus.res_last   <= last_dft;
      end else if (poll_to) begin
        bus.res_data   <= '0;
        bus.res_is_dft <= state == POLL_DFT;
        bus.res_last   <= 1'b1;
      end
    end
endmodule

// File: tb/tb_axi_test_sequencer.sv
// tb_axi_test_sequencer: directed vectors against two sequencer configurations sharing one register model
module tb_axi_test_sequencer;
  logic clk = 1'b0, reset = 1'b0, sel = 1'b0;
  logic cmd_val = 1'b0, res_rdy = 1'b1;
  logic [31:0] cmd_data = '0;
  logic busy_a, busy_b, err_a, err_b;
  int n_chk = 0, n_pass = 0;
  axi_seq_if ia();
  axi_seq_if ib();
  axi_test_sequencer #(.DUMP_NBR(1), .TIMEOUT(4)) dut_a (.clk(clk), .reset(reset), .bus(ia), .busy(busy_a), .err(err_a));
  axi_test_sequencer #(.DUMP_NBR(3), .TIMEOUT(4)) dut_b (.clk(clk), .reset(reset), .bus(ib), .busy(busy_b), .err(err_b));
  always #5 clk = ~clk;
  logic [31:0] rd_msg = '0, mode = '0, out_val = '0, dft_base = '0;
  int polls = 0, stat_reads = 0, dft_idx = 0, act = 0, dut_need = 1, dft_need = 1;
  logic [31:0] wlog_a[$], wlog_m[$];
  assign ia.cmd_val = cmd_val && !sel;
  assign ib.cmd_val = cmd_val && sel;
  assign ia.cmd_data = cmd_data;
  assign ib.cmd_data = cmd_data;
  assign ia.res_rdy = res_rdy;
  assign ib.res_rdy = res_rdy;
  assign ia.axi_rd_msg = rd_msg;
  assign ib.axi_rd_msg = rd_msg;
  wire        o_cmd_rdy = sel ? ib.cmd_rdy : ia.cmd_rdy;
  wire        o_res_val = sel ? ib.res_val : ia.res_val;
  wire [31:0] o_res_data = sel ? ib.res_data : ia.res_data;
  wire        o_res_dft = sel ? ib.res_is_dft : ia.res_is_dft;
  wire        o_res_last = sel ? ib.res_last : ia.res_last;
  wire [31:0] o_wr_addr = sel ? ib.axi_wr_addr : ia.axi_wr_addr;
  wire [31:0] o_wr_msg = sel ? ib.axi_wr_msg : ia.axi_wr_msg;
  wire [31:0] o_rd_addr = sel ? ib.axi_rd_addr : ia.axi_rd_addr;
  wire        o_busy = sel ? busy_b : busy_a;
  wire        o_err = sel ? err_b : err_a;
  // register model: STAT bit rises on the Nth poll since the latest CTRL write
  always @(posedge clk) begin
    rd_msg <= '0;
    if (o_wr_addr != 32'h0) begin
      wlog_a.push_back(o_wr_addr);
      wlog_m.push_back(o_wr_msg);
      if (o_wr_addr == 32'h8) begin
        mode  <= o_wr_msg;
        polls <= 0;
        if (o_wr_msg == 32'h1) dft_idx <= 0;
      end
    end
    if (o_wr_addr != 32'h0 || o_rd_addr != 32'h0) act <= act + 1;
    if (o_rd_addr == 32'hC) begin
      stat_reads <= stat_reads + 1;
      polls <= polls + 1;
      rd_msg <= {30'd0, mode == 32'h2 && dft_need != 0 && polls + 1 >= dft_need,
                        mode == 32'h1 && dut_need != 0 && polls + 1 >= dut_need};
    end
    if (o_rd_addr == 32'h10) rd_msg <= out_val;
    if (o_rd_addr == 32'h14) begin
      rd_msg <= dft_base + 32'(dft_idx);
      dft_idx <= dft_idx + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic send(input logic [31:0] d);
    @(negedge clk);
    cmd_val = 1'b1;
    cmd_data = d;
    @(posedge clk);
    #1 cmd_val = 1'b0;
  endtask
  task automatic get_res(output logic [31:0] d, output logic f, output logic l, output int lat);
    logic found = 1'b0;
    lat = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      lat++;
      found = o_res_val;
    end
    check("res_valid_seen", found, 1'b1);
    d = o_res_data;
    f = o_res_dft;
    l = o_res_last;
  endtask
  initial begin
    logic [31:0] d, d2;
    logic f, l, f2, l2, found, stable;
    int lat, w0, s0, a0;
    logic [31:0] exp_d[4];
    repeat (2) @(negedge clk);
    check("rst_cmd_rdy", ia.cmd_rdy, 1'b0);
    check("rst_res_val", ia.res_val, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    check("rst_wr_addr", ia.axi_wr_addr, 32'h0);
    check("rst_wr_msg", ia.axi_wr_msg, 32'h0);
    check("rst_rd_addr", ia.axi_rd_addr, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_cmd_rdy", o_cmd_rdy, 1'b1);
    // basic run: DUT done on first poll, one dump word
    dut_need = 1; dft_need = 1; out_val = 32'h1234; dft_base = 32'hDEAD;
    w0 = wlog_a.size();
    send(32'hA5A5_0001);
    get_res(d, f, l, lat);
    check("t1_lat", lat, 7);
    check("t1_out_data", d, 32'h1234);
    check("t1_out_dft", f, 1'b0);
    check("t1_out_last", l, 1'b0);
    get_res(d, f, l, lat);
    check("t1_dft_data", d, 32'hDEAD);
    check("t1_dft_dft", f, 1'b1);
    check("t1_dft_last", l, 1'b1);
    repeat (2) @(negedge clk);
    check("t1_nwrites", wlog_a.size() - w0, 3);
    check("t1_w0_addr", wlog_a[w0], 32'h4);
    check("t1_w0_msg", wlog_m[w0], 32'hA5A5_0001);
    check("t1_w1_addr", wlog_a[w0+1], 32'h8);
    check("t1_w1_msg", wlog_m[w0+1], 32'h1);
    check("t1_w2_addr", wlog_a[w0+2], 32'h8);
    check("t1_w2_msg", wlog_m[w0+2], 32'h2);
    check("t1_idle", o_busy, 1'b0);
    // three DUT polls
    dut_need = 3; s0 = stat_reads;
    send(32'h2);
    get_res(d, f, l, lat);
    check("t2_lat", lat, 11);
    check("t2_stat_reads", stat_reads - s0, 3);
    get_res(d, f, l, lat);
    // DUT never completes
    dut_need = 0; s0 = stat_reads;
    send(32'h3);
    get_res(d, f, l, lat);
    check("t3_data", d, 32'h0);
    check("t3_dft", f, 1'b0);
    check("t3_last", l, 1'b1);
    check("t3_err", o_err, 1'b1);
    check("t3_stat_reads", stat_reads - s0, 4);
    @(negedge clk);
    check("t3_idle", o_busy, 1'b0);
    check("t3_err_sticky", o_err, 1'b1);
    dut_need = 1;
    send(32'h4);
    @(negedge clk);
    check("t3_err_cleared", o_err, 1'b0);
    get_res(d, f, l, lat);
    get_res(d, f, l, lat);
    // three dump words with a stall on the second result word
    sel = 1'b1; dut_need = 2; dft_need = 1; out_val = 32'h0BEE; dft_base = 32'h100;
    send(32'h5);
    get_res(d, f, l, lat);
    check("t4_w1_data", d, 32'h0BEE);
    check("t4_w1_last", l, 1'b0);
    @(negedge clk);
    res_rdy = 1'b0;
    get_res(d, f, l, lat);
    check("t4_w2_data", d, 32'h100);
    check("t4_w2_dft", f, 1'b1);
    check("t4_w2_last", l, 1'b0);
    a0 = act; stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!o_res_val || o_res_data !== d || o_res_dft !== f || o_res_last !== l) stable = 1'b0;
    end
    check("t4_stall_stable", stable, 1'b1);
    check("t4_stall_no_axi", act, a0);
    res_rdy = 1'b1;
    get_res(d, f, l, lat);
    check("t4_w3_data", d, 32'h101);
    check("t4_w3_last", l, 1'b0);
    get_res(d, f, l, lat);
    check("t4_w4_data", d, 32'h102);
    check("t4_w4_last", l, 1'b1);
    found = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_res_val) found = 1'b1;
    end
    check("t4_no_extra_word", found, 1'b0);
    check("t4_idle", o_busy, 1'b0);
    // reset asserted while polling for a dump strobe
    dut_need = 1; dft_need = 0;
    send(32'h6);
    get_res(d, f, l, lat);
    @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = o_rd_addr == 32'hC;
    end
    check("t5_in_poll_dft", found, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t5_busy", o_busy, 1'b0);
    check("t5_res_val", o_res_val, 1'b0);
    check("t5_rd_addr", o_rd_addr, 32'h0);
    check("t5_wr_addr", o_wr_addr, 32'h0);
    check("t5_cmd_rdy", o_cmd_rdy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    dft_need = 1; out_val = 32'h77; dft_base = 32'h200;
    exp_d = '{32'h77, 32'h200, 32'h201, 32'h202};
    send(32'h7);
    for (int k = 0; k < 4; k++) begin
      get_res(d, f, l, lat);
      check($sformatf("t5_w%0d_data", k), d, exp_d[k]);
      check($sformatf("t5_w%0d_last", k), l, k == 3);
    end
    // command pulses while busy are ignored
    sel = 1'b0; dut_need = 2;
    repeat (2) @(negedge clk);
    w0 = wlog_a.size();
    send(32'h0000_C0DE);
    @(negedge clk);
    cmd_val = 1'b1;
    cmd_data = 32'hBAD;
    check("t6_busy_rdy", o_cmd_rdy, 1'b0);
    repeat (3) @(negedge clk);
    cmd_val = 1'b0;
    get_res(d, f, l, lat);
    get_res(d2, f2, l2, lat);
    check("t6_last", l2, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_nwrites", wlog_a.size() - w0, 3);
    check("t6_in_msg", wlog_m[w0], 32'h0000_C0DE);
    check("t6_idle", o_busy, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
